// File: rtl/gear_edc_seq.sv
// gear_edc_seq: GeAr(N,R,P) approximate adder with sequential per-sub-adder error detection and correction
module gear_edc_seq #(
    parameter int N = 8,
    parameter int R = 1,
    parameter int P = 2,
    parameter int SW = 16,
    localparam int K = (N - P) / R,
    localparam int CW = $clog2(K) + 1,
    localparam int IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in1,
    input  logic [N-1:0]  in2,
    input  logic          corr_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N:0]    res,
    output logic          err_det,
    output logic [CW-1:0] err_cnt,
    input  logic          stat_clr,
    output logic [SW-1:0] stat_ops,
    output logic [SW-1:0] stat_err
);
    typedef enum logic [1:0] {IDLE, EVAL, CORR, DONE} state_t;
    state_t state;
    logic [N-1:0] a, b, p, c;
    logic ce;
    logic [K-1:0] err_vec, errv, err_nxt;
    logic [IW-1:0] idx;
    logic [N:0] full, appr;
    logic [P+R:0] win0 [K];
    logic [P+R:0] win1 [K];
    logic [CW-1:0] pop;

    function automatic logic [IW-1:0] lowest(input logic [K-1:0] v);
        lowest = '0;
        for (int j = K - 1; j >= 0; j--)
            if (v[j]) lowest = IW'(j);
    endfunction

    // c recovers the exact carry into each bit from the exact sum and the propagate vector
    always_comb begin
        p = a ^ b;
        full = {1'b0, a} + {1'b0, b};
        c = full[N-1:0] ^ p;
        appr = '0;
        errv = '0;
        pop = '0;
        for (int j = 0; j < K; j++) begin
            win0[j] = (P+R+1)'(a[j*R +: P+R]) + (P+R+1)'(b[j*R +: P+R]);
            win1[j] = win0[j] + (P+R+1)'(1);
        end
        appr[P+R-1:0] = win0[0][P+R-1:0];
        for (int j = 1; j < K; j++) begin
            appr[j*R+P +: R] = win0[j][P +: R];
            errv[j] = c[j*R] & (&p[j*R +: P]);
        end
        appr[N] = win0[K-1][P+R];
        for (int j = 0; j < K; j++)
            pop = pop + CW'(errv[j]);
        err_nxt = err_vec & ~(K'(1) << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            res <= '0;
            err_det <= 1'b0;
            err_cnt <= '0;
            a <= '0;
            b <= '0;
            ce <= 1'b0;
            err_vec <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a <= in1;
                    b <= in2;
                    ce <= corr_en;
                    in_ready <= 1'b0;
                    state <= EVAL;
                end
                EVAL: begin
                    res <= appr;
                    err_vec <= errv;
                    err_det <= |errv;
                    err_cnt <= pop;
                    idx <= lowest(errv);
                    state <= (errv == '0 || !ce) ? DONE : CORR;
                    out_valid <= (errv == '0 || !ce);
                end
                CORR: begin
                    res[idx*R+P +: R] <= win1[idx][P +: R];
                    if (idx == IW'(K-1)) res[N] <= win1[idx][P+R];
                    err_vec <= err_nxt;
                    idx <= lowest(err_nxt);
                    state <= (err_nxt == '0) ? DONE : CORR;
                    out_valid <= (err_nxt == '0);
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
            stat_err <= '0;
        end else if (stat_clr) begin
            stat_ops <= '0;
            stat_err <= '0;
        end else if (state == DONE && out_ready) begin
            stat_ops <= stat_ops + SW'(stat_ops != '1);
            stat_err <= stat_err + SW'(err_det && stat_err != '1);
        end
    end
endmodule

// File: tb/tb_gear_edc_seq.sv
// tb_gear_edc_seq: directed and random checks of gear_edc_seq (N8 R1 P2); a 2-bit-stats twin covers saturation
module tb_gear_edc_seq;
    logic clk = 0, rst = 1;
    logic in_valid = 0, corr_en = 0, out_ready = 0, stat_clr = 0;
    logic [7:0] in1 = 0, in2 = 0;
    logic in_ready, out_valid, err_det;
    logic [8:0] res;
    logic [3:0] err_cnt;
    logic [15:0] stat_ops, stat_err;
    logic s_in_ready, s_out_valid, s_err_det;
    logic [8:0] s_res;
    logic [3:0] s_err_cnt;
    logic [1:0] s_stat_ops, s_stat_err;
    logic [8:0] trace [0:16];
    logic [8:0] exp3 [0:4];
    int nvec = 0, nbad = 0, mops = 0, merr = 0, cyc;

    always #5 clk = ~clk;

    gear_edc_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .err_det(err_det), .err_cnt(err_cnt), .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_err(stat_err)
    );

    gear_edc_seq #(.SW(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in1(in1), .in2(in2),
        .corr_en(corr_en), .out_valid(s_out_valid), .out_ready(out_ready), .res(s_res),
        .err_det(s_err_det), .err_cnt(s_err_cnt), .stat_clr(stat_clr), .stat_ops(s_stat_ops), .stat_err(s_stat_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ce, output int cy);
        int n;
        in1 = a;
        in2 = b;
        corr_en = ce;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        n = 0;
        trace[0] = res;
        while (!out_valid && n < 16) begin
            @(posedge clk);
            #1 n++;
            trace[n] = res;
        end
        cy = n + 1;
        if (!out_valid) check("timeout", 0, 1);
    endtask

    task automatic finish_op(input logic clr);
        logic det;
        det = err_det;
        out_ready = 1;
        stat_clr = clr;
        @(posedge clk);
        #1 out_ready = 0;
        stat_clr = 0;
        if (clr) begin
            mops = 0;
            merr = 0;
        end else begin
            mops++;
            merr += int'(det);
        end
    endtask

    // Reference GeAr N8R1P2: 3-bit windows at every bit offset, carry-in 0
    function automatic logic [8:0] gear(input logic [7:0] a, input logic [7:0] b);
        int s;
        gear = '0;
        s = (a & 7) + (b & 7);
        gear[2:0] = s[2:0];
        for (int j = 1; j <= 5; j++) begin
            s = ((a >> j) & 7) + ((b >> j) & 7);
            gear[j+2] = s[2];
            if (j == 5) gear[8] = s[3];
        end
    endfunction

    function automatic int nerr(input logic [7:0] a, input logic [7:0] b);
        int m, cin;
        nerr = 0;
        for (int j = 1; j <= 5; j++) begin
            m = (1 << j) - 1;
            cin = (((a & m) + (b & m)) >> j) & 1;
            if (cin == 1 && (((a ^ b) >> j) & 3) == 3) nerr++;
        end
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        logic ce;
        int e, x;
        exp3[0] = 9'h0F0; exp3[1] = 9'h0E0; exp3[2] = 9'h0C0; exp3[3] = 9'h080; exp3[4] = 9'h100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_res", res, 0);
        check("rst_err", {err_det, err_cnt}, 0);
        check("rst_stats", {stat_ops, stat_err}, 0);
        rst = 0;
        @(posedge clk);
        #1;
        run_op(8'h35, 8'h42, 1, cyc);
        check("t1_res", res, 9'h077);
        check("t1_err", {err_det, err_cnt}, 0);
        check("t1_lat", cyc, 2);
        finish_op(0);
        run_op(8'h07, 8'h01, 1, cyc);
        check("t2_eval_res", trace[1], 9'h000);
        check("t2_res", res, 9'h008);
        check("t2_cnt", err_cnt, 1);
        check("t2_lat", cyc, 3);
        finish_op(0);
        run_op(8'hFF, 8'h01, 1, cyc);
        check("t3_eval_res", trace[1], 9'h0F8);
        check("t3_cnt", err_cnt, 5);
        check("t3_lat", cyc, 7);
        for (int i = 0; i < 5; i++) check($sformatf("t3_corr%0d", i), trace[i+2], exp3[i]);
        finish_op(0);
        run_op(8'hFF, 8'h01, 0, cyc);
        check("t4_res", res, 9'h0F8);
        check("t4_det", err_det, 1);
        check("t4_cnt", err_cnt, 5);
        check("t4_lat", cyc, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_res", res, 9'h0F8);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_ops", stat_ops, 3);
        end
        finish_op(0);
        check("stat_ops4", stat_ops, 4);
        check("stat_err4", stat_err, 3);
        check("sat_ops_small", s_stat_ops, 3);
        check("sat_err_small", s_stat_err, 3);
        in1 = 8'hFF; in2 = 8'h01; corr_en = 1; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        check("mid_rst_res", res, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_err", {err_det, err_cnt}, 0);
        check("mid_rst_stats", {stat_ops, stat_err}, 0);
        @(negedge clk);
        rst = 0;
        mops = 0;
        merr = 0;
        @(posedge clk);
        #1;
        run_op(8'h35, 8'h42, 1, cyc);
        check("post_rst_res", res, 9'h077);
        check("post_rst_lat", cyc, 2);
        finish_op(0);
        for (int i = 0; i < 10000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ce = 1'($urandom_range(0, 1));
            run_op(a, b, ce, cyc);
            e = nerr(a, b);
            x = ce ? (int'(a) + int'(b)) : int'(gear(a, b));
            check("rnd_res", res, x);
            check("rnd_cnt", err_cnt, e);
            check("rnd_lat", cyc, 2 + (ce ? e : 0));
            finish_op(0);
        end
        check("rnd_stat_ops", stat_ops, mops);
        check("rnd_stat_err", stat_err, merr);
        check("rnd_sat_ops", s_stat_ops, 3);
        check("rnd_sat_err", s_stat_err, (merr > 3) ? 3 : merr);
        run_op(8'h12, 8'h34, 1, cyc);
        finish_op(1);
        check("clr_ops", stat_ops, 0);
        check("clr_err", stat_err, 0);
        check("clr_ops_small", s_stat_ops, 0);
        run_op(8'hFF, 8'h01, 1, cyc);
        finish_op(0);
        check("after_clr_ops", stat_ops, 1);
        check("after_clr_err", stat_err, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
